// File: rtl/seq_driver_pkg.sv
// Shared types and constants for the sequence driver and its receiver.
// Driver state encoding plus min/max reset values.
package seq_driver_pkg;

    typedef logic       ulogic1;
    typedef logic [7:0] ulogic8;
    typedef logic [1:0] ulogic2;

    typedef enum ulogic2 {
        DRV_IDLE   = 2'd0,
        DRV_STREAM = 2'd1,
        DRV_WAIT   = 2'd2,
        DRV_REPORT = 2'd3
    } drv_state_t;

    localparam ulogic8 MIN_INIT = 8'd255;
    localparam ulogic8 MAX_INIT = 8'd0;

    function automatic ulogic8 max8(ulogic8 a, ulogic8 b);
        return (a > b) ? a : b;
    endfunction

    function automatic ulogic8 min8(ulogic8 a, ulogic8 b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_driver_if.sv
// Driver <-> receiver link: burst stream out, done and min/max back.
// master is the driver side, slave the receiver side.
interface seq_driver_if;
    import seq_driver_pkg::*;

    ulogic1 start;
    ulogic8 dataOut;
    ulogic1 done_in;
    ulogic8 maxIn;
    ulogic8 minIn;

    modport master (
        output start, dataOut,
        input  done_in, maxIn, minIn
    );

    modport slave (
        input  start, dataOut,
        output done_in, maxIn, minIn
    );

endinterface

// File: rtl/seq_driver_byte_buffer.sv
// Append-only byte list with clear and combinational indexed read.
// Writes beyond DEPTH entries are dropped.
module seq_driver_byte_buffer
    import seq_driver_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  ulogic1                     clk,
    input  ulogic1                     reset_n,
    input  ulogic1                     wr,
    input  ulogic1                     clr,
    input  ulogic8                     wdata,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [$clog2(DEPTH):0]     count,
    output ulogic8                     rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    ulogic8 mem [DEPTH];
    ulogic1 full;

    assign full  = (count == FULL);
    assign rdata = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr && !full) begin
            count <= count + CW'(1);
        end
    end

    // Contents need no reset: count gates what is visible.
    always_ff @(posedge clk) begin
        if (reset_n && wr && !clr && !full) begin
            mem[count[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/seq_driver.sv
// Replays a buffered byte list to the min/max receiver as one burst,
// then captures the receiver's result and checks it against its own.
module seq_driver
    import seq_driver_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 8
) (
    input  ulogic1                 clk,
    input  ulogic1                 reset_n,
    input  ulogic1                 wr_en,
    input  ulogic8                 wr_data,
    input  ulogic1                 clear,
    input  ulogic1                 go,
    output ulogic1                 busy,
    output logic [$clog2(DEPTH):0] count,
    seq_driver_if.master           rx,
    output ulogic1                 resultValid,
    output ulogic8                 maxResult,
    output ulogic8                 minResult,
    output ulogic1                 mismatch,
    output ulogic1                 timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    drv_state_t    state;
    logic [CW-1:0] rd;
    logic [TW-1:0] wcnt;
    ulogic8        rdata;
    ulogic8        exp_max;
    ulogic8        exp_min;
    ulogic1        idle;
    ulogic1        go_ok;
    ulogic1        buf_wr;
    ulogic1        buf_clr;

    // Host commands only act in IDLE; clear beats go, go beats wr_en.
    assign idle    = (state == DRV_IDLE);
    assign go_ok   = idle && go && !clear && (count != '0);
    assign buf_clr = idle && clear;
    assign buf_wr  = idle && wr_en && !clear && !go_ok;

    seq_driver_byte_buffer #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (buf_wr),
        .clr     (buf_clr),
        .wdata   (wr_data),
        .rd_idx  (rd[AW-1:0]),
        .count   (count),
        .rdata   (rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= DRV_IDLE;
            busy        <= 1'b0;
            rd          <= '0;
            wcnt        <= '0;
            rx.start    <= 1'b0;
            rx.dataOut  <= 8'd0;
            resultValid <= 1'b0;
            maxResult   <= MAX_INIT;
            minResult   <= MIN_INIT;
            mismatch    <= 1'b0;
            timeout     <= 1'b0;
            exp_max     <= MAX_INIT;
            exp_min     <= MIN_INIT;
        end else begin
            resultValid <= 1'b0;
            unique case (state)
                DRV_IDLE: begin
                    if (go_ok) begin
                        rd      <= '0;
                        exp_max <= MAX_INIT;
                        exp_min <= MIN_INIT;
                        busy    <= 1'b1;
                        state   <= DRV_STREAM;
                    end
                end
                DRV_STREAM: begin
                    if (rd != count) begin
                        rx.start   <= 1'b1;
                        rx.dataOut <= rdata;
                        exp_max    <= max8(exp_max, rdata);
                        exp_min    <= min8(exp_min, rdata);
                        rd         <= rd + CW'(1);
                    end else begin
                        rx.start   <= 1'b0;
                        rx.dataOut <= 8'd0;
                        wcnt       <= '0;
                        state      <= DRV_WAIT;
                    end
                end
                DRV_WAIT: begin
                    if (rx.done_in) begin
                        maxResult   <= rx.maxIn;
                        minResult   <= rx.minIn;
                        mismatch    <= (rx.maxIn != exp_max) ||
                                       (rx.minIn != exp_min);
                        timeout     <= 1'b0;
                        resultValid <= 1'b1;
                        state       <= DRV_REPORT;
                    end else if (wcnt == TLAST) begin
                        mismatch    <= 1'b0;
                        timeout     <= 1'b1;
                        resultValid <= 1'b1;
                        state       <= DRV_REPORT;
                    end else begin
                        wcnt <= wcnt + TW'(1);
                    end
                end
                DRV_REPORT: begin
                    busy  <= 1'b0;
                    state <= DRV_IDLE;
                end
                default: state <= DRV_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_driver.md
Name: seq_driver

Overview:
- Transmit-side partner for the min/max sequence receiver.
- Buffers a list of unsigned bytes from a host write port, replays them as a contiguous burst (start held high, one byte per cycle), then waits for the receiver's done pulse.
- Captures the receiver's max/min, checks them against its own running max/min of the sent bytes, and reports pass/fail.
- Sits between a test/host controller and the receiver, and serves as both stimulus source and self-check.

Parameters:
- DEPTH, 16, byte buffer entries (power of 2, ≥2)
- TIMEOUT, 8, cycles to wait for done_in after start drops before declaring timeout

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- wr_en  in  1  append wr_data to buffer (ignored while busy or full)
- wr_data  in  8  byte to append
- clear  in  1  empty buffer (ignored while busy)
- go  in  1  begin burst (ignored while busy or empty)
- busy  out  1  high in any state other than IDLE
- count  out  $clog2(DEPTH)+1  bytes currently buffered
- start  out  1  to receiver: high for exactly count cycles per burst
- dataOut  out  8  to receiver: byte for the current cycle
- done_in  in  1  from receiver done
- maxIn  in  8  from receiver maxValue
- minIn  in  8  from receiver minValue
- resultValid  out  1  one-cycle pulse when a burst concludes
- maxResult  out  8  captured maxIn
- minResult  out  8  captured minIn
- mismatch  out  1  valid with resultValid: captured ≠ expected
- timeout  out  1  valid with resultValid: done_in never arrived

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE, count 0, start 0, dataOut 0, resultValid 0, maxResult 0, minResult 255, mismatch 0, timeout 0, expected max 0, expected min 255. Reset wins over every other input and aborts a burst mid-stream; start is low from the next edge.
- All outputs are registered. 2-bit state.
- IDLE:
  - wr_en && count<DEPTH: write buffer[count], count+1. When full, the write is dropped and count is unchanged.
  - clear: count=0. clear and wr_en together: clear wins.
  - go && count>0: read pointer=0, expected max=0, min=255, → STREAM. go with count==0 is ignored.
  - go has priority over a same-cycle wr_en (the write is dropped).
- STREAM:
  - Each cycle, drive start=1 and dataOut=buffer[rd], update expected max/min with that byte, rd+1.
  - The first byte appears on the edge after go is sampled.
  - After byte count-1 is driven, the next edge gives start=0, dataOut=0 → WAIT with wait counter 0.
  - wr_en, clear and go are ignored.
- WAIT:
  - done_in sampled high: latch maxIn→maxResult, minIn→minResult; mismatch=(maxIn≠expMax)||(minIn≠expMin); timeout=0 → REPORT.
  - done_in low: counter+1. At TIMEOUT, timeout=1, mismatch=0, results unchanged → REPORT.
  - done_in high during STREAM is ignored (not early completion).
- REPORT: resultValid=1 for one cycle → IDLE. Buffer contents and count are preserved, so go replays the same list. mismatch and timeout hold until the next REPORT.
- Comparisons are unsigned 8-bit. Boundary bytes 0 and 255 are legal data.

Decomposition:
- Shared package definitions.pkg: ulogic1/ulogic8 typedefs (existing), a new driver state enum (DRV_IDLE, DRV_STREAM, DRV_WAIT, DRV_REPORT) as ulogic2 constants, and the reset constants MIN_INIT=8'd255 and MAX_INIT=8'd0 shared with the receiver.
- One sub-module, byte_buffer: DEPTH×8 register array with write pointer/count, clear, and combinational read by index.
- FSM, expected min/max tracking and result capture live in seq_driver.

Test Plan:
- Write 3,9,1,7; go → start high 4 cycles with dataOut 3,9,1,7; done_in with maxIn=9, minIn=1 → resultValid, mismatch=0, timeout=0.
- Same burst, receiver returns maxIn=9, minIn=3 → mismatch=1, minResult=3.
- Single byte 0xFF; go → start high exactly 1 cycle; done_in with max=min=255 → mismatch=0.
- Burst with done_in held low → resultValid exactly TIMEOUT cycles after start falls, timeout=1.
- Write DEPTH+2 bytes → count=DEPTH, extra writes dropped. go with count 0 after clear → no start, busy stays 0.
- reset_n low on the 2nd STREAM cycle → next edge start=0, count=0, all outputs at reset values. wr_en/clear/go during STREAM have no effect.
